// File: rtl/shift_sequencer.sv
// shift_sequencer: 0-31 bit logical shifts in <=7-bit passes through an 8-bit barrel shifter; SHIFT_SEQ_ROTATE_EN adds rotate
module barrel_shifter (
  input  logic [7:0] in,
  input  logic [2:0] sh,
  input  logic       dir,
  output logic [7:0] out
);
  assign out = dir ? in << sh : in >> sh;
endmodule

module shift_sequencer #(
  parameter int DATA_W  = 8,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [DATA_W-1:0]  in,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               dir,
`ifdef SHIFT_SEQ_ROTATE_EN
  input  logic               rot,
`endif
  output logic               busy,
  output logic               done,
  output logic [DATA_W-1:0]  out
);
  typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;
  state_t state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d, out_q, out_d, sh_out, pass_out;
  logic [SHAMT_W-1:0] rem_q, rem_d, amt;
  logic dir_q, dir_d, done_q, done_d;
  logic [2:0] pass;
  assign pass = rem_q > SHAMT_W'(7) ? 3'd7 : rem_q[2:0];
  barrel_shifter u_fwd (.in(acc_q), .sh(pass), .dir(dir_q), .out(sh_out));
`ifdef SHIFT_SEQ_ROTATE_EN
  logic rot_q, rot_d;
  logic [DATA_W-1:0] sh_back;
  barrel_shifter u_back (.in(acc_q), .sh(3'd0 - pass), .dir(!dir_q), .out(sh_back));
  assign pass_out = rot_q ? sh_out | sh_back : sh_out;
  assign amt = rot ? SHAMT_W'(shamt[2:0]) : shamt;
  assign rot_d = (state_q == IDLE && start) ? rot : rot_q;
  always_ff @(posedge clk)
    rot_q <= !rst_n ? 1'b0 : rot_d;
`else
  assign pass_out = sh_out;
  assign amt = shamt;
`endif
  always_comb begin
    state_d = state_q;
    acc_d = acc_q;
    rem_d = rem_q;
    dir_d = dir_q;
    case (state_q)
      IDLE: if (start) begin
        acc_d = in;
        rem_d = amt;
        dir_d = dir;
        state_d = amt != '0 ? SHIFT : FIN;
      end
      SHIFT: begin
        acc_d = pass_out;
        rem_d = rem_q - SHAMT_W'(pass);
        state_d = rem_q <= SHAMT_W'(7) ? FIN : SHIFT;
      end
      default: state_d = IDLE;
    endcase
    done_d = state_d == FIN;
    out_d = done_d ? acc_d : out_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q <= '0;
      rem_q <= '0;
      dir_q <= 1'b0;
      done_q <= 1'b0;
      out_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      rem_q <= rem_d;
      dir_q <= dir_d;
      done_q <= done_d;
      out_q <= out_d;
    end
  end
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign out = out_q;
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: scoreboard bench for shift_sequencer; rotate cases run when SHIFT_SEQ_ROTATE_EN is defined
module tb_shift_sequencer;
  logic clk = 0, rst_n = 0, start = 0, dir = 0, rot = 0;
  logic [7:0] in_v = 0;
  logic [4:0] shamt = 0;
  logic busy, done;
  logic [7:0] out_v;
  int tests = 0, fails = 0;
  typedef struct { logic [7:0] res; int lat; } exp_t;
  exp_t sb[$];
`ifdef SHIFT_SEQ_ROTATE_EN
  localparam bit HAS_ROT = 1'b1;
`else
  localparam bit HAS_ROT = 1'b0;
`endif
  always #5 clk = ~clk;
  shift_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in(in_v), .shamt(shamt), .dir(dir),
`ifdef SHIFT_SEQ_ROTATE_EN
    .rot(rot),
`endif
    .busy(busy), .done(done), .out(out_v)
  );
  function automatic exp_t model(input logic [7:0] i, input logic [4:0] s, input logic d, input logic r);
    exp_t e;
    logic [2:0] k;
    k = s[2:0];
    if (r) begin
      e.res = k == 0 ? i : d ? 8'((i << k) | (i >> (4'd8 - {1'b0, k}))) : 8'((i >> k) | (i << (4'd8 - {1'b0, k})));
      e.lat = k == 0 ? 1 : 2;
    end else begin
      e.res = s >= 5'd8 ? 8'h00 : d ? 8'(i << s) : 8'(i >> s);
      e.lat = s == 0 ? 1 : (int'(s) + 6) / 7 + 1;
    end
    return e;
  endfunction
  task automatic send(input logic [7:0] i, input logic [4:0] s, input logic d, input logic r, input logic [7:0] er, input int el);
    in_v = i;
    shamt = s;
    dir = d;
    rot = r;
    start = 1;
    sb.push_back('{er, el});
    @(posedge clk);
    #1;
    start = 0;
  endtask
  task automatic wait_done(output logic [7:0] o, output int lat, output int nb);
    lat = -1;
    nb = 0;
    o = 8'hxx;
    for (int n = 1; n <= 20; n++) begin
      if (busy) nb++;
      if (done) begin
        lat = n;
        o = out_v;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask
  task automatic test_reset;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    @(posedge clk);
    #1;
    tests++; if (out_v !== 8'h00) begin fails++; $display("FAIL reset_out got %h want 00", out_v); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
  endtask
  task automatic test_shift;
    logic [7:0] ti[7] = '{8'h66, 8'h66, 8'h76, 8'h76, 8'hFF, 8'hA5, 8'h80};
    logic [4:0] ts[7] = '{5'd3, 5'd3, 5'd5, 5'd5, 5'd31, 5'd0, 5'd8};
    logic td[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [7:0] tr[7] = '{8'h30, 8'h0C, 8'hC0, 8'h03, 8'h00, 8'hA5, 8'h00};
    int tl[7] = '{2, 2, 2, 2, 6, 1, 3};
    logic [7:0] o;
    int lat, nb;
    exp_t e;
    for (int n = 0; n < 7; n++) begin
      send(ti[n], ts[n], td[n], 1'b0, tr[n], tl[n]);
      wait_done(o, lat, nb);
      e = sb.pop_front();
      tests++; if (o !== e.res) begin fails++; $display("FAIL shift_out[%0d] got %h want %h", n, o, e.res); end
      tests++; if (lat != e.lat) begin fails++; $display("FAIL shift_lat[%0d] got %0d want %0d", n, lat, e.lat); end
      tests++; if (nb != e.lat) begin fails++; $display("FAIL shift_busy[%0d] got %0d want %0d", n, nb, e.lat); end
      @(posedge clk);
      #1;
      tests++; if ({busy, done} !== 2'b00) begin fails++; $display("FAIL shift_after[%0d] busy,done got %b want 00", n, {busy, done}); end
    end
  endtask
  task automatic test_ignore_busy;
    logic [7:0] o;
    int lat, nb;
    exp_t e;
    send(8'h66, 5'd3, 1'b1, 1'b0, 8'h30, 2);
    in_v = 8'hFF;
    shamt = 5'd0;
    dir = 1'b0;
    start = 1;
    wait_done(o, lat, nb);
    start = 0;
    e = sb.pop_front();
    tests++; if (o !== e.res) begin fails++; $display("FAIL ignore_out got %h want %h", o, e.res); end
    tests++; if (lat != e.lat) begin fails++; $display("FAIL ignore_lat got %0d want %0d", lat, e.lat); end
    repeat (2) begin
      @(posedge clk);
      #1;
      tests++; if ({busy, done} !== 2'b00) begin fails++; $display("FAIL ignore_idle busy,done got %b want 00", {busy, done}); end
    end
  endtask
  task automatic test_back_to_back;
    logic [7:0] o;
    int lat, nb;
    exp_t e;
    in_v = 8'h76;
    shamt = 5'd5;
    dir = 1'b1;
    rot = 1'b0;
    start = 1;
    sb.push_back('{8'hC0, 2});
    sb.push_back('{8'hA5, 1});
    @(posedge clk);
    #1;
    in_v = 8'hA5;
    shamt = 5'd0;
    wait_done(o, lat, nb);
    e = sb.pop_front();
    tests++; if (o !== e.res) begin fails++; $display("FAIL b2b_first_out got %h want %h", o, e.res); end
    tests++; if (lat != e.lat) begin fails++; $display("FAIL b2b_first_lat got %0d want %0d", lat, e.lat); end
    @(posedge clk);
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL b2b_gap_busy got %b want 0", busy); end
    @(posedge clk);
    #1;
    start = 0;
    e = sb.pop_front();
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL b2b_second_done got %b want 1", done); end
    tests++; if (out_v !== e.res) begin fails++; $display("FAIL b2b_second_out got %h want %h", out_v, e.res); end
    @(posedge clk);
    #1;
  endtask
  task automatic test_mid_reset;
    int pulses;
    send(8'hFF, 5'd31, 1'b1, 1'b0, 8'h00, 6);
    void'(sb.pop_back());
    @(posedge clk);
    #1;
    rst_n = 0;
    @(posedge clk);
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midrst_busy got %b want 0", busy); end
    tests++; if (out_v !== 8'h00) begin fails++; $display("FAIL midrst_out got %h want 00", out_v); end
    rst_n = 1;
    pulses = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    tests++; if (pulses != 0) begin fails++; $display("FAIL midrst_done got %0d pulses want 0", pulses); end
  endtask
  task automatic test_rotate;
    logic [4:0] ts[4] = '{5'd5, 5'd5, 5'd13, 5'd8};
    logic td[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [7:0] tr[4] = '{8'hCE, 8'hB3, 8'hCE, 8'h76};
    int tl[4] = '{2, 2, 2, 1};
    logic [7:0] o;
    int lat, nb;
    exp_t e;
    for (int n = 0; n < 4; n++) begin
      send(8'h76, ts[n], td[n], 1'b1, tr[n], tl[n]);
      wait_done(o, lat, nb);
      e = sb.pop_front();
      tests++; if (o !== e.res) begin fails++; $display("FAIL rot_out[%0d] got %h want %h", n, o, e.res); end
      tests++; if (lat != e.lat) begin fails++; $display("FAIL rot_lat[%0d] got %0d want %0d", n, lat, e.lat); end
      @(posedge clk);
      #1;
    end
  endtask
  task automatic test_random;
    logic [7:0] i, o;
    logic [4:0] s;
    logic d, r;
    int lat, nb;
    exp_t e;
    for (int n = 0; n < 24; n++) begin
      i = 8'($urandom);
      s = 5'($urandom);
      d = 1'($urandom);
      r = HAS_ROT ? 1'($urandom) : 1'b0;
      e = model(i, s, d, r);
      send(i, s, d, r, e.res, e.lat);
      in_v = ~i;
      shamt = ~s;
      dir = ~d;
      wait_done(o, lat, nb);
      e = sb.pop_front();
      tests++; if (o !== e.res) begin fails++; $display("FAIL rand_out[%0d] in=%h sh=%0d dir=%b rot=%b got %h want %h", n, i, s, d, r, o, e.res); end
      tests++; if (lat != e.lat) begin fails++; $display("FAIL rand_lat[%0d] got %0d want %0d", n, lat, e.lat); end
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    test_reset();
    test_shift();
    test_ignore_busy();
    test_back_to_back();
    test_mid_reset();
    if (HAS_ROT) test_rotate();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
